// File: rtl/loadstore_dispatch.sv
// loadstore_dispatch: buffers issue-stage memory operations in a small FIFO and
// hands legal ones to the data memory one at a time; illegal ones are dropped and reported.
module loadstore_dispatch #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       Flush,
  output logic                       Issue_REQ,
  input  logic                       Issue_ACK,
  input  logic [3:0]                 Issue_MinorOpcode,
  input  logic [REGADDRBITWIDTH-1:0] Issue_DestRegister,
  input  logic [DATABITWIDTH-1:0]    Issue_DataAddr,
  input  logic [DATABITWIDTH-1:0]    Issue_Data,
  input  logic                       LoadStore_REQ,
  output logic                       LoadStore_ACK,
  output logic [3:0]                 MinorOpcodeOut,
  output logic [REGADDRBITWIDTH-1:0] DestRegisterOut,
  output logic [DATABITWIDTH-1:0]    DataAddrOut,
  output logic [DATABITWIDTH-1:0]    DataOut,
  output logic                       Fault,
  output logic [DATABITWIDTH-1:0]    FaultAddr,
  output logic [3:0]                 FaultOpcode,
  output logic                       Idle,
  output logic [15:0]                DispatchCount,
  output logic [1:0]                 o_dbg_head_state
);
  localparam int          PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    HS_EMPTY           = 2'd0,
    HS_PRESENT_LEGAL   = 2'd1,
    HS_PRESENT_ILLEGAL = 2'd2
  } head_state_e;

  logic [3:0]                 r_op   [DEPTH];
  logic [REGADDRBITWIDTH-1:0] r_dst  [DEPTH];
  logic [DATABITWIDTH-1:0]    r_addr [DEPTH];
  logic [DATABITWIDTH-1:0]    r_data [DEPTH];
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [PW:0]                r_count;
  logic [15:0]                r_dispatch_count;
  logic [DATABITWIDTH-1:0]    r_fault_addr;
  logic [3:0]                 r_fault_op;

  logic        w_empty;
  logic        w_full;
  logic        w_illegal;
  logic        w_issue_req;
  logic        w_ls_ack;
  logic        w_fault;
  logic        w_push;
  logic        w_pop;
  head_state_e w_head_state;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_COUNT);
  // Double/quad are never executable; a word must sit on an even byte address.
  assign w_illegal = r_op[r_rptr][1] | ((r_op[r_rptr][1:0] == 2'b01) & r_addr[r_rptr][0]);

  always_comb begin
    w_head_state = HS_EMPTY;
    if (!w_empty) w_head_state = w_illegal ? HS_PRESENT_ILLEGAL : HS_PRESENT_LEGAL;
  end

  // Both channels use valid/ready: a transfer happens on a rising edge where the
  // producer's valid (Issue_ACK / LoadStore_ACK) and the consumer's ready
  // (Issue_REQ / LoadStore_REQ) are both high; valid never depends on ready.
  assign w_issue_req = ~w_full & ~Flush & clk_en;
  assign w_ls_ack    = (w_head_state == HS_PRESENT_LEGAL) & clk_en & ~Flush;
  assign w_fault     = (w_head_state == HS_PRESENT_ILLEGAL) & clk_en & ~Flush;
  assign w_push      = Issue_ACK & w_issue_req;
  assign w_pop       = (w_ls_ack & LoadStore_REQ) | w_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr           <= '0;
      r_rptr           <= '0;
      r_count          <= '0;
      r_dispatch_count <= '0;
      r_fault_addr     <= '0;
      r_fault_op       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]   <= '0;
        r_dst[i]  <= '0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (clk_en) begin
      if (Flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_op[r_wptr]   <= Issue_MinorOpcode;
          r_dst[r_wptr]  <= Issue_DestRegister;
          r_addr[r_wptr] <= Issue_DataAddr;
          r_data[r_wptr] <= Issue_Data;
          r_wptr         <= r_wptr + PW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        if (w_push && !w_pop) r_count <= r_count + (PW+1)'(1);
        else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
        if (w_ls_ack && LoadStore_REQ) r_dispatch_count <= r_dispatch_count + 16'd1;
        if (w_fault) begin
          r_fault_addr <= r_addr[r_rptr];
          r_fault_op   <= r_op[r_rptr];
        end
      end
    end
  end

  assign Issue_REQ        = w_issue_req;
  assign LoadStore_ACK    = w_ls_ack;
  assign Fault            = w_fault;
  assign MinorOpcodeOut   = r_op[r_rptr];
  assign DestRegisterOut  = r_dst[r_rptr];
  assign DataAddrOut      = r_addr[r_rptr];
  assign DataOut          = r_data[r_rptr];
  assign FaultAddr        = r_fault_addr;
  assign FaultOpcode      = r_fault_op;
  assign Idle             = w_empty;
  assign DispatchCount    = r_dispatch_count;
  assign o_dbg_head_state = w_head_state;
endmodule

// File: tb/tb_loadstore_dispatch.sv
// Bench for loadstore_dispatch: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a queue-based model of the dispatcher.
module tb_loadstore_dispatch;
  localparam int DW      = 16;
  localparam int RW      = 4;
  localparam int DEPTH   = 4;
  localparam int ENTRY_W = 4 + RW + DW + DW;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic          flush;
  logic          issue_req;
  logic          issue_ack;
  logic [3:0]    issue_op;
  logic [RW-1:0] issue_dst;
  logic [DW-1:0] issue_addr;
  logic [DW-1:0] issue_data;
  logic          ls_req;
  logic          ls_ack;
  logic [3:0]    op_out;
  logic [RW-1:0] dst_out;
  logic [DW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          fault;
  logic [DW-1:0] fault_addr;
  logic [3:0]    fault_op;
  logic          idle;
  logic [15:0]   dcount;
  logic [1:0]    dbg_state;

  loadstore_dispatch #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .Flush(flush),
    .Issue_REQ(issue_req), .Issue_ACK(issue_ack), .Issue_MinorOpcode(issue_op),
    .Issue_DestRegister(issue_dst), .Issue_DataAddr(issue_addr), .Issue_Data(issue_data),
    .LoadStore_REQ(ls_req), .LoadStore_ACK(ls_ack),
    .MinorOpcodeOut(op_out), .DestRegisterOut(dst_out), .DataAddrOut(addr_out), .DataOut(data_out),
    .Fault(fault), .FaultAddr(fault_addr), .FaultOpcode(fault_op),
    .Idle(idle), .DispatchCount(dcount), .o_dbg_head_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int unsigned         n_checks = 0;
  int unsigned         n_pass   = 0;
  logic [ENTRY_W-1:0]  exp_q[$];
  int unsigned         m_dcnt;
  logic [DW-1:0]       m_faddr;
  logic [3:0]          m_fop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Memory executes only naturally aligned accesses of at most 2 bytes.
  function automatic logic is_illegal(input logic [3:0] op, input logic [DW-1:0] addr);
    int unsigned nbytes;
    nbytes = 1 << op[1:0];
    return (nbytes > 2) || ((int'(addr) % nbytes) != 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic fl, input logic iack, input logic [3:0] op,
                       input logic [RW-1:0] dst, input logic [DW-1:0] addr,
                       input logic [DW-1:0] data, input logic lsreq);
    clk_en     = en;
    flush      = fl;
    issue_ack  = iack;
    issue_op   = op;
    issue_dst  = dst;
    issue_addr = addr;
    issue_data = data;
    ls_req     = lsreq;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'h0, '0, '0, '0, 1'b0);
    exp_q.delete();
    m_dcnt  = 0;
    m_faddr = '0;
    m_fop   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic model_step(input logic en, input logic fl, input logic iack, input logic [3:0] op,
                            input logic [RW-1:0] dst, input logic [DW-1:0] addr,
                            input logic [DW-1:0] data, input logic lsreq);
    logic [ENTRY_W-1:0] head;
    logic               nonempty, bad, x_ireq, x_ack, x_fault;
    drive(en, fl, iack, op, dst, addr, data, lsreq);
    #2;
    nonempty = (exp_q.size() != 0);
    head     = nonempty ? exp_q[0] : '0;
    bad      = is_illegal(head[ENTRY_W-1 -: 4], head[2*DW-1 -: DW]);
    x_ireq   = en && !fl && (exp_q.size() < DEPTH);
    x_ack    = en && !fl && nonempty && !bad;
    x_fault  = en && !fl && nonempty && bad;
    if (en) check("issue_req", issue_req, x_ireq);
    check("ls_ack", ls_ack, x_ack);
    check("fault", fault, x_fault);
    check("idle", idle, !nonempty);
    check("dispatch_count", dcount, 16'(m_dcnt));
    check("fault_addr", fault_addr, m_faddr);
    check("fault_op", fault_op, m_fop);
    if (nonempty) check("head_fields", {op_out, dst_out, addr_out, data_out}, head);
    @(posedge clk);
    #1;
    if (en) begin
      if (fl) exp_q.delete();
      else begin
        if ((x_ack && lsreq) || x_fault) begin
          void'(exp_q.pop_front());
          if (x_ack) m_dcnt++;
          else begin
            m_fop   = head[ENTRY_W-1 -: 4];
            m_faddr = head[2*DW-1 -: DW];
          end
        end
        if (iack && x_ireq) exp_q.push_back({op, dst, addr, data});
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          en, fl, iack;
    logic [3:0]    op;
    logic [DW-1:0] addr, data;
    logic          lsreq;
    logic          x_ireq, x_ack, x_fault, x_idle;
    logic [15:0]   x_dcnt;
    logic [DW-1:0] x_faddr;
    logic [3:0]    x_fop;
    logic [3:0]    x_op;
    logic [DW-1:0] x_addr, x_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 0, 1, 4'h5, 16'h0010, 16'hBEEF, 1,  1, 0, 0, 1, 16'd0, 16'h0000, 4'h0,  4'h0, 16'h0000, 16'h0000};
    vecs[1] = '{1, 0, 0, 4'h0, 16'h0000, 16'h0000, 1,  1, 1, 0, 0, 16'd0, 16'h0000, 4'h0,  4'h5, 16'h0010, 16'hBEEF};
    vecs[2] = '{1, 0, 1, 4'h1, 16'h0003, 16'h0000, 1,  1, 0, 0, 1, 16'd1, 16'h0000, 4'h0,  4'h0, 16'h0000, 16'h0000};
    vecs[3] = '{1, 0, 1, 4'h0, 16'h0003, 16'h0000, 1,  1, 0, 1, 0, 16'd1, 16'h0000, 4'h0,  4'h1, 16'h0003, 16'h0000};
    vecs[4] = '{1, 0, 0, 4'h0, 16'h0000, 16'h0000, 1,  1, 1, 0, 0, 16'd1, 16'h0003, 4'h1,  4'h0, 16'h0003, 16'h0000};
    vecs[5] = '{1, 0, 1, 4'h6, 16'h0020, 16'h1234, 1,  1, 0, 0, 1, 16'd2, 16'h0003, 4'h1,  4'h0, 16'h0000, 16'h0000};
    vecs[6] = '{1, 0, 0, 4'h0, 16'h0000, 16'h0000, 1,  1, 0, 1, 0, 16'd2, 16'h0003, 4'h1,  4'h6, 16'h0020, 16'h1234};
    vecs[7] = '{1, 0, 0, 4'h0, 16'h0000, 16'h0000, 1,  1, 0, 0, 1, 16'd2, 16'h0020, 4'h6,  4'h0, 16'h0000, 16'h0000};

    apply_reset();
    check("reset_issue_req", issue_req, 1'b1);
    check("reset_ls_ack", ls_ack, 1'b0);
    check("reset_fault", fault, 1'b0);
    check("reset_idle", idle, 1'b1);
    check("reset_dcount", dcount, 16'd0);
    check("reset_fault_addr", fault_addr, 16'h0000);
    check("reset_fault_op", fault_op, 4'h0);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].en, vecs[i].fl, vecs[i].iack, vecs[i].op, 4'h3, vecs[i].addr, vecs[i].data, vecs[i].lsreq);
      #2;
      check($sformatf("vec%0d_issue_req", i), issue_req, vecs[i].x_ireq);
      check($sformatf("vec%0d_ls_ack", i), ls_ack, vecs[i].x_ack);
      check($sformatf("vec%0d_fault", i), fault, vecs[i].x_fault);
      check($sformatf("vec%0d_idle", i), idle, vecs[i].x_idle);
      check($sformatf("vec%0d_dcount", i), dcount, vecs[i].x_dcnt);
      check($sformatf("vec%0d_fault_addr", i), fault_addr, vecs[i].x_faddr);
      check($sformatf("vec%0d_fault_op", i), fault_op, vecs[i].x_fop);
      if (!vecs[i].x_idle) begin
        check($sformatf("vec%0d_op_out", i), op_out, vecs[i].x_op);
        check($sformatf("vec%0d_addr_out", i), addr_out, vecs[i].x_addr);
        check($sformatf("vec%0d_data_out", i), data_out, vecs[i].x_data);
      end
      @(posedge clk);
      #1;
    end

    // ---------------- full FIFO, refused push, in-order drain ----------------
    apply_reset();
    for (int i = 0; i < 4; i++)
      model_step(1, 0, 1, 4'h0, RW'(i), DW'(16'h0100 + 2 * i), DW'(i), 0);
    #1 check("full_issue_req", issue_req, 1'b0);
    model_step(1, 0, 1, 4'h0, 4'hF, 16'h0200, 16'hDEAD, 0);
    for (int i = 0; i < 4; i++) model_step(1, 0, 0, 4'h0, '0, '0, '0, 1);
    check("drain_dcount", dcount, 16'd4);
    check("drain_idle", idle, 1'b1);

    // ---------------- flush with a concurrent push ----------------
    for (int i = 0; i < 3; i++) model_step(1, 0, 1, 4'h4, '0, DW'(16'h0300 + i), DW'(i), 0);
    model_step(1, 1, 1, 4'h0, '0, 16'h0400, 16'h0000, 0);
    check("flush_idle", idle, 1'b1);
    check("flush_dcount", dcount, 16'd4);
    model_step(1, 0, 0, 4'h0, '0, '0, '0, 1);

    // ---------------- clk_en hold, then async reset mid-stream ----------------
    for (int i = 0; i < 4; i++) model_step(1, 0, 1, 4'h5, '0, DW'(16'h0500 + 2 * i), DW'(i), 0);
    for (int i = 0; i < 3; i++) model_step(0, 0, 1, 4'h0, '0, 16'h0600, 16'h0000, 1);
    model_step(1, 0, 0, 4'h0, '0, '0, '0, 1);
    drive(1, 0, 0, 4'h0, '0, '0, '0, 0);
    #2 check("pre_reset_ls_ack", ls_ack, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_idle", idle, 1'b1);
    check("async_reset_dcount", dcount, 16'd0);
    check("async_reset_ls_ack", ls_ack, 1'b0);
    apply_reset();

    // ---------------- randomized traffic against the model ----------------
    for (int i = 0; i < 400; i++)
      model_step(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), RW'($urandom),
                 DW'($urandom), DW'($urandom), logic'($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
